// File: rtl/meduram_nwmr.sv
// meduram_nwmr: parametrised multi-port scratch RAM.
// NB_WR write ports and NB_RD read ports share one clock domain.
// The storage is a flop array written only by collision winners.
// Reads are registered with a one-cycle latency and a valid flag per port.
// Same-address read-during-write is either bypassed (WRITE_FIRST=1) or
// returns the old contents (WRITE_FIRST=0).
// Out-of-range writes are dropped. Out-of-range reads return zero.
module meduram_nwmr #(
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_DEPTH   = 2 ** ADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int NB_WR       = 2,
    parameter int NB_RD       = 2,
    parameter int WRITE_FIRST = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NB_WR-1:0]            wren,
    input  logic [NB_WR*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_WR*DATA_WIDTH-1:0] wrdata,
    input  logic [NB_RD-1:0]            rden,
    input  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RD*DATA_WIDTH-1:0] rddata,
    output logic [NB_RD-1:0]            rdvalid,
    output logic                        wr_collision
);

    // One extra bit keeps the compare exact when RAM_DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [NB_WR-1:0]      wr_ok;
    logic [NB_WR-1:0]      wr_win;
    logic                  collision;
    logic [DATA_WIDTH-1:0] rd_next [NB_RD];

    // Qualify the writes and arbitrate them: the lowest enabled in-range port wins per address.
    always_comb begin
        wr_ok     = '0;
        wr_win    = '0;
        collision = 1'b0;
        for (int i = 0; i < NB_WR; i++) begin
            wr_ok[i] = wren[i] &&
                       ({1'b0, wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_LIM);
        end
        for (int i = 0; i < NB_WR; i++) begin
            wr_win[i] = wr_ok[i];
            for (int k = 0; k < i; k++) begin
                if (wr_ok[k] && wr_ok[i] &&
                    (wraddr[k*ADDR_WIDTH +: ADDR_WIDTH] == wraddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    wr_win[i] = 1'b0;
                    collision = 1'b1;
                end
            end
        end
    end

    // Build the next read word for each port: array contents, optional write bypass, or zero when out of range.
    always_comb begin
        for (int j = 0; j < NB_RD; j++) begin
            rd_next[j] = '0;
            if ({1'b0, rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_LIM) begin
                rd_next[j] = mem[rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
                if (WRITE_FIRST != 0) begin
                    for (int i = 0; i < NB_WR; i++) begin
                        if (wr_win[i] &&
                            (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            rd_next[j] = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    // Commit the winning writes. Contents are never cleared, and writes are discarded while reset is held.
    always_ff @(posedge aclk) begin
        if (!areset) begin
            for (int i = 0; i < NB_WR; i++) begin
                if (wr_win[i]) begin
                    mem[wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wrdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Register the read data, valid flags and collision pulse. Data holds its value when no read is issued.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rddata       <= '0;
            rdvalid      <= '0;
            wr_collision <= 1'b0;
        end else begin
            rdvalid      <= rden;
            wr_collision <= collision;
            for (int j = 0; j < NB_RD; j++) begin
                if (rden[j]) begin
                    rddata[j*DATA_WIDTH +: DATA_WIDTH] <= rd_next[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_meduram_nwmr.sv
// tb_meduram_nwmr: directed self-checking bench for meduram_nwmr.
// Two instances share the same inputs. dut is write-first and dut_rf is
// read-first, and both have RAM_DEPTH=200 so the out-of-range behaviour is
// reachable.
module tb_meduram_nwmr;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int NR = 2;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [NW-1:0]     wren = '0;
    logic [NW*AW-1:0]  wraddr = '0;
    logic [NW*DW-1:0]  wrdata = '0;
    logic [NR-1:0]     rden = '0;
    logic [NR*AW-1:0]  rdaddr = '0;
    logic [NR*DW-1:0]  rddata, rddata_rf;
    logic [NR-1:0]     rdvalid, rdvalid_rf;
    logic              wr_collision, wr_collision_rf;

    int n_cmp = 0;
    int n_err = 0;

    meduram_nwmr #(
        .ADDR_WIDTH(AW), .RAM_DEPTH(200), .DATA_WIDTH(DW),
        .NB_WR(NW), .NB_RD(NR), .WRITE_FIRST(1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rden(rden), .rdaddr(rdaddr),
        .rddata(rddata), .rdvalid(rdvalid), .wr_collision(wr_collision)
    );

    meduram_nwmr #(
        .ADDR_WIDTH(AW), .RAM_DEPTH(200), .DATA_WIDTH(DW),
        .NB_WR(NW), .NB_RD(NR), .WRITE_FIRST(0)
    ) dut_rf (
        .aclk(aclk), .areset(areset),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rden(rden), .rdaddr(rdaddr),
        .rddata(rddata_rf), .rdvalid(rdvalid_rf), .wr_collision(wr_collision_rf)
    );

    // Free-running 100 MHz clock.
    always #5 aclk = ~aclk;

    task automatic set_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wren[p]             = 1'b1;
        wraddr[p*AW +: AW]  = a;
        wrdata[p*DW +: DW]  = d;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        rden[p]             = 1'b1;
        rdaddr[p*AW +: AW]  = a;
    endtask

    // Advance one edge, settle 1 ns, then idle all enables for the next cycle.
    task automatic step();
        @(posedge aclk);
        #1;
        wren = '0;
        rden = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge aclk);
        #1;
        n_cmp++; if (rddata !== '0) begin n_err++; $display("[TB] FAIL reset_rddata: got %h expected 0", rddata); end
        n_cmp++; if (rdvalid !== 2'b00) begin n_err++; $display("[TB] FAIL reset_rdvalid: got %b expected 00", rdvalid); end
        n_cmp++; if (wr_collision !== 1'b0) begin n_err++; $display("[TB] FAIL reset_collision: got %b expected 0", wr_collision); end
        areset = 1'b0;
    endtask

    task automatic test_write_read();
        set_write(1, 8'd100, 32'h0000BEEF);
        step();
        set_read(1, 8'd100);
        step();
        n_cmp++; if (rddata[DW +: DW] !== 32'h0000BEEF) begin n_err++; $display("[TB] FAIL wr_rd_data: got %h expected 0000beef", rddata[DW +: DW]); end
        n_cmp++; if (rdvalid !== 2'b10) begin n_err++; $display("[TB] FAIL wr_rd_valid: got %b expected 10", rdvalid); end
        step();
        n_cmp++; if (rdvalid !== 2'b00) begin n_err++; $display("[TB] FAIL wr_rd_valid_drop: got %b expected 00", rdvalid); end
        n_cmp++; if (rddata[DW +: DW] !== 32'h0000BEEF) begin n_err++; $display("[TB] FAIL wr_rd_hold: got %h expected 0000beef", rddata[DW +: DW]); end
    endtask

    task automatic test_dual_write();
        set_write(0, 8'd5, 32'h00001111);
        set_write(1, 8'd6, 32'h00002222);
        step();
        n_cmp++; if (wr_collision !== 1'b0) begin n_err++; $display("[TB] FAIL dual_no_coll: got %b expected 0", wr_collision); end
        set_read(0, 8'd6);
        set_read(1, 8'd5);
        step();
        n_cmp++; if (rddata[0 +: DW] !== 32'h00002222) begin n_err++; $display("[TB] FAIL dual_rd0: got %h expected 00002222", rddata[0 +: DW]); end
        n_cmp++; if (rddata[DW +: DW] !== 32'h00001111) begin n_err++; $display("[TB] FAIL dual_rd1: got %h expected 00001111", rddata[DW +: DW]); end
        n_cmp++; if (rdvalid !== 2'b11) begin n_err++; $display("[TB] FAIL dual_valid: got %b expected 11", rdvalid); end
        n_cmp++; if (wr_collision !== 1'b0) begin n_err++; $display("[TB] FAIL dual_coll_low: got %b expected 0", wr_collision); end
    endtask

    task automatic test_collision();
        set_write(0, 8'd7, 32'h0000AAAA);
        set_write(1, 8'd7, 32'h0000BBBB);
        step();
        n_cmp++; if (wr_collision !== 1'b1) begin n_err++; $display("[TB] FAIL coll_pulse: got %b expected 1", wr_collision); end
        step();
        n_cmp++; if (wr_collision !== 1'b0) begin n_err++; $display("[TB] FAIL coll_one_cycle: got %b expected 0", wr_collision); end
        set_read(1, 8'd7);
        step();
        n_cmp++; if (rddata[DW +: DW] !== 32'h0000AAAA) begin n_err++; $display("[TB] FAIL coll_winner: got %h expected 0000aaaa", rddata[DW +: DW]); end
        // A colliding write combined with a same-edge read: the bypass must carry the winner.
        set_write(0, 8'd12, 32'h00000C0C);
        set_write(1, 8'd12, 32'h0000DDDD);
        set_read(0, 8'd12);
        step();
        n_cmp++; if (rddata[0 +: DW] !== 32'h00000C0C) begin n_err++; $display("[TB] FAIL coll_bypass: got %h expected 00000c0c", rddata[0 +: DW]); end
    endtask

    task automatic test_rdw();
        set_write(0, 8'd9, 32'h00001234);
        step();
        set_write(0, 8'd9, 32'h00005678);
        set_read(1, 8'd9);
        step();
        n_cmp++; if (rddata[DW +: DW] !== 32'h00005678) begin n_err++; $display("[TB] FAIL rdw_write_first: got %h expected 00005678", rddata[DW +: DW]); end
        n_cmp++; if (rddata_rf[DW +: DW] !== 32'h00001234) begin n_err++; $display("[TB] FAIL rdw_read_first: got %h expected 00001234", rddata_rf[DW +: DW]); end
        set_read(1, 8'd9);
        step();
        n_cmp++; if (rddata_rf[DW +: DW] !== 32'h00005678) begin n_err++; $display("[TB] FAIL rdw_read_first_next: got %h expected 00005678", rddata_rf[DW +: DW]); end
    endtask

    task automatic test_out_of_range();
        set_write(0, 8'd50, 32'h0000CAFE);
        step();
        set_write(1, 8'd250, 32'h0000DEAD);
        step();
        set_read(0, 8'd250);
        step();
        n_cmp++; if (rddata[0 +: DW] !== 32'h0) begin n_err++; $display("[TB] FAIL oor_rd_zero: got %h expected 00000000", rddata[0 +: DW]); end
        n_cmp++; if (rdvalid[0] !== 1'b1) begin n_err++; $display("[TB] FAIL oor_rd_valid: got %b expected 1", rdvalid[0]); end
        set_read(1, 8'd50);
        step();
        n_cmp++; if (rddata[DW +: DW] !== 32'h0000CAFE) begin n_err++; $display("[TB] FAIL oor_in_range_kept: got %h expected 0000cafe", rddata[DW +: DW]); end
        set_write(0, 8'd250, 32'h00000001);
        set_write(1, 8'd250, 32'h00000002);
        step();
        n_cmp++; if (wr_collision !== 1'b0) begin n_err++; $display("[TB] FAIL oor_no_coll: got %b expected 0", wr_collision); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] exp_d [3];
        addrs = '{8'd5, 8'd6, 8'd50};
        exp_d = '{32'h00001111, 32'h00002222, 32'h0000CAFE};
        set_read(0, addrs[0]);
        for (int n = 0; n < 3; n++) begin
            @(posedge aclk);
            #1;
            rden = '0;
            if (n < 2) set_read(0, addrs[n+1]);
            n_cmp++; if (rddata[0 +: DW] !== exp_d[n]) begin n_err++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", n, rddata[0 +: DW], exp_d[n]); end
            n_cmp++; if (rdvalid[0] !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", n, rdvalid[0]); end
        end
    endtask

    task automatic test_reset_midop();
        set_read(0, 8'd100);
        #2;
        areset = 1'b1;
        #1;
        n_cmp++; if (rdvalid !== 2'b00) begin n_err++; $display("[TB] FAIL midrst_async_valid: got %b expected 00", rdvalid); end
        @(posedge aclk);
        #1;
        n_cmp++; if (rdvalid !== 2'b00) begin n_err++; $display("[TB] FAIL midrst_valid: got %b expected 00", rdvalid); end
        n_cmp++; if (rddata !== '0) begin n_err++; $display("[TB] FAIL midrst_data: got %h expected 0", rddata); end
        areset = 1'b0;
        rden = '0;
        set_read(1, 8'd100);
        step();
        n_cmp++; if (rddata[DW +: DW] !== 32'h0000BEEF) begin n_err++; $display("[TB] FAIL midrst_mem_kept: got %h expected 0000beef", rddata[DW +: DW]); end
        n_cmp++; if (rdvalid !== 2'b10) begin n_err++; $display("[TB] FAIL midrst_valid_after: got %b expected 10", rdvalid); end
    endtask

    // Run all scenarios in order, then print the summary.
    initial begin
        test_reset();
        test_write_read();
        test_dual_write();
        test_collision();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
